// File: rtl/reverb_channel_scheduler.sv
// Shares one reverb core between the left and right channels: gathers an L/R pair,
// issues L then R to the core, returns both results as a frame, latching coefficients per frame.
module reverb_channel_scheduler #(
  parameter int DATA_W = 24,
  parameter int COEF_W = 25,
  parameter int MIX_W  = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] l_in_data,
  input  logic              l_in_valid,
  output logic              l_in_ready,
  input  logic [DATA_W-1:0] r_in_data,
  input  logic              r_in_valid,
  output logic              r_in_ready,
  output logic [DATA_W-1:0] l_out_data,
  output logic              l_out_valid,
  input  logic              l_out_ready,
  output logic [DATA_W-1:0] r_out_data,
  output logic              r_out_valid,
  input  logic              r_out_ready,
  output logic [DATA_W-1:0] core_in_data,
  output logic              core_in_right,
  output logic              core_in_valid,
  input  logic              core_in_ready,
  input  logic [DATA_W-1:0] core_out_data,
  input  logic              core_out_valid,
  input  logic [COEF_W-1:0] decay_in,
  input  logic [COEF_W-1:0] damping_in,
  input  logic [MIX_W-1:0]  mix_in,
  output logic [COEF_W-1:0] decay_q,
  output logic [COEF_W-1:0] damping_q,
  output logic [MIX_W-1:0]  mix_q,
  output logic              seq_err,
  output logic [15:0]       frame_cnt
);

  typedef enum logic [2:0] {
    S_COLLECT = 3'd0,
    S_ISSUE_L = 3'd1,
    S_WAIT_L  = 3'd2,
    S_ISSUE_R = 3'd3,
    S_WAIT_R  = 3'd4,
    S_OUTPUT  = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic                l_full_q, l_full_d, r_full_q, r_full_d;
  logic [DATA_W-1:0]   l_data_q, l_data_d, r_data_q, r_data_d;
  logic [DATA_W-1:0]   l_res_q, l_res_d, r_res_q, r_res_d;
  logic                l_out_valid_q, l_out_valid_d, r_out_valid_q, r_out_valid_d;
  logic                l_in_ready_q, l_in_ready_d, r_in_ready_q, r_in_ready_d;
  logic                seq_err_q, seq_err_d;
  logic [COEF_W-1:0]   decay_d, damping_d;
  logic [MIX_W-1:0]    mix_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic                l_take, r_take, both_done;

  assign l_take    = l_in_valid & l_in_ready_q;
  assign r_take    = r_in_valid & r_in_ready_q;
  assign both_done = (~l_out_valid_q | l_out_ready) & (~r_out_valid_q | r_out_ready);

  assign l_in_ready    = l_in_ready_q;
  assign r_in_ready    = r_in_ready_q;
  assign l_out_data    = l_res_q;
  assign r_out_data    = r_res_q;
  assign l_out_valid   = l_out_valid_q;
  assign r_out_valid   = r_out_valid_q;
  assign seq_err       = seq_err_q;
  assign frame_cnt     = frame_cnt_q;
  assign core_in_valid = (state_q == S_ISSUE_L) | (state_q == S_ISSUE_R);
  assign core_in_right = (state_q == S_ISSUE_R);
  assign core_in_data  = (state_q == S_ISSUE_R) ? r_data_q :
                         ((state_q == S_ISSUE_L) ? l_data_q : '0);

  // Frame sequencing, input capture and result collection
  always_comb begin
    state_d       = state_q;
    l_full_d      = l_full_q;
    r_full_d      = r_full_q;
    l_data_d      = l_data_q;
    r_data_d      = r_data_q;
    l_res_d       = l_res_q;
    r_res_d       = r_res_q;
    l_out_valid_d = l_out_valid_q;
    r_out_valid_d = r_out_valid_q;
    decay_d       = decay_q;
    damping_d     = damping_q;
    mix_d         = mix_q;
    frame_cnt_d   = frame_cnt_q;
    seq_err_d     = seq_err_q;

    if (l_take) begin
      l_full_d = 1'b1;
      l_data_d = l_in_data;
    end
    if (r_take) begin
      r_full_d = 1'b1;
      r_data_d = r_in_data;
    end

    // A result strobe is only legal while a request is outstanding
    if (core_out_valid && (state_q != S_WAIT_L) && (state_q != S_WAIT_R)) begin
      seq_err_d = 1'b1;
    end

    case (state_q)
      S_COLLECT: begin
        // Looks at this cycle's captures so a pair completing now starts the frame at once
        if ((l_full_q | l_take) & (r_full_q | r_take)) begin
          state_d   = S_ISSUE_L;
          decay_d   = decay_in;
          damping_d = damping_in;
          mix_d     = mix_in;
        end
      end
      S_ISSUE_L: if (core_in_ready) state_d = S_WAIT_L;
      S_WAIT_L: begin
        if (core_out_valid) begin
          l_res_d = core_out_data;
          state_d = S_ISSUE_R;
        end
      end
      S_ISSUE_R: if (core_in_ready) state_d = S_WAIT_R;
      S_WAIT_R: begin
        if (core_out_valid) begin
          r_res_d       = core_out_data;
          l_out_valid_d = 1'b1;
          r_out_valid_d = 1'b1;
          state_d       = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        if (l_out_ready) l_out_valid_d = 1'b0;
        if (r_out_ready) r_out_valid_d = 1'b0;
        if (both_done) begin
          l_full_d    = 1'b0;
          r_full_d    = 1'b0;
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = S_COLLECT;
        end
      end
      default: state_d = S_COLLECT;
    endcase

    l_in_ready_d = (state_d == S_COLLECT) & ~l_full_d;
    r_in_ready_d = (state_d == S_COLLECT) & ~r_full_d;
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_COLLECT;
      l_full_q      <= 1'b0;
      r_full_q      <= 1'b0;
      l_data_q      <= '0;
      r_data_q      <= '0;
      l_res_q       <= '0;
      r_res_q       <= '0;
      l_out_valid_q <= 1'b0;
      r_out_valid_q <= 1'b0;
      l_in_ready_q  <= 1'b0;
      r_in_ready_q  <= 1'b0;
      seq_err_q     <= 1'b0;
      decay_q       <= '0;
      damping_q     <= '0;
      mix_q         <= '0;
      frame_cnt_q   <= 16'd0;
    end else begin
      state_q       <= state_d;
      l_full_q      <= l_full_d;
      r_full_q      <= r_full_d;
      l_data_q      <= l_data_d;
      r_data_q      <= r_data_d;
      l_res_q       <= l_res_d;
      r_res_q       <= r_res_d;
      l_out_valid_q <= l_out_valid_d;
      r_out_valid_q <= r_out_valid_d;
      l_in_ready_q  <= l_in_ready_d;
      r_in_ready_q  <= r_in_ready_d;
      seq_err_q     <= seq_err_d;
      decay_q       <= decay_d;
      damping_q     <= damping_d;
      mix_q         <= mix_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

endmodule
